wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl_pkg.sv | 41 ++++
 rtl/wb_ctrl_if.sv | 27 ++
 rtl/wb_ctrl.sv | 79 +++++++
 tb/tb_wb_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the writeback controller.
package wb_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_MEM   = 3'd1,
    ST_WAIT_SHIFT = 3'd2,
    ST_WRITE      = 3'd3,
    ST_DONE       = 3'd4,
    ST_ERR        = 3'd5
  } state_t;

  // Writeback source / mux select encoding
  typedef logic [2:0] sel_t;

  localparam sel_t SEL_ALU       = 3'd0;
  localparam sel_t SEL_LOAD      = 3'd1;
  localparam sel_t SEL_SHIFT     = 3'd2;
  localparam sel_t SEL_LINK      = 3'd3;
  localparam sel_t SEL_LUI       = 3'd4;
  localparam sel_t SEL_SIGNEXT   = 3'd5;
  localparam sel_t SEL_EXC_CONST = 3'd6;
  localparam sel_t SEL_INVALID   = 3'd7;

  // Default number of WAIT_MEM cycles tolerated before an error
  localparam int MEM_TIMEOUT_DEFAULT = 16;

  // State entered from IDLE when a request of the given class is accepted
  function automatic state_t entry_state(input sel_t op);
    state_t st;
    case (op)
      SEL_LOAD:    st = ST_WAIT_MEM;
      SEL_SHIFT:   st = ST_WAIT_SHIFT;
      SEL_INVALID: st = ST_ERR;
      default:     st = ST_WRITE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Request/handshake/writeback-control bundle between requester and controller.
interface wb_ctrl_if;
  import wb_ctrl_pkg::*;

  logic start;
  sel_t op_class;
  logic mem_ready;
  logic shift_done;
  sel_t w_MemToReg;
  logic RegWrite;
  logic busy;
  logic done;
  logic err;

  // Requester side: issues requests and handshakes, observes control
  modport master (
    output start, op_class, mem_ready, shift_done,
    input  w_MemToReg, RegWrite, busy, done, err
  );

  // Controller side
  modport slave (
    input  start, op_class, mem_ready, shift_done,
    output w_MemToReg, RegWrite, busy, done, err
  );

endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller FSM: accepts a request in IDLE, waits for the load or
// shift result where needed, then issues a one-cycle register write and a
// completion pulse (or an error pulse for timeouts and invalid classes).
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  wb_ctrl_if.slave bus
);

  // Counter is wide enough to hold MEM_TIMEOUT itself.
  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, latched select and timeout counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_ALU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; handshakes are only looked at in their own wait state
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_d   = bus.op_class;
          state_d = entry_state(bus.op_class);
        end
      end
      ST_WAIT_MEM: begin
        if (bus.mem_ready) begin
          // Data arriving on the last allowed cycle still wins over timeout
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_WAIT_SHIFT: begin
        if (bus.shift_done) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and select
  always_comb begin
    bus.busy       = (state_q != ST_IDLE);
    bus.RegWrite   = (state_q == ST_WRITE);
    bus.done       = (state_q == ST_DONE);
    bus.err        = (state_q == ST_ERR);
    bus.w_MemToReg = (state_q == ST_IDLE) ? SEL_ALU : sel_q;
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl (MEM_TIMEOUT = 4).
module tb_wb_ctrl;

  logic clk;
  logic reset;

  int total;
  int bad;

  wb_ctrl_if bus ();

  wb_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vector: cycle 0 is the start cycle; -1 means "never"
  typedef struct {
    int op;
    int hs_lo;
    int hs_hi;
    int rw_cyc;
    int done_cyc;
    int err_cyc;
  } vec_t;

  localparam int NVEC   = 15;
  localparam int WINDOW = 12;

  vec_t vecs[NVEC];

  task automatic check(input string name, input int idx, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d want %0d", name, idx, got, want);
    end
  endtask

  function automatic int outs_packed();
    return {25'd0, bus.w_MemToReg, bus.RegWrite, bus.busy, bus.done, bus.err};
  endfunction

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.op_class   = 3'd0;
    bus.mem_ready  = 1'b0;
    bus.shift_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rw_first, rw_n, done_first, done_n, err_first, err_n, busy_n, sel_bad, idle_bad, end_cyc, misc;

    total = 0;
    bad   = 0;

    //            op hs_lo hs_hi rw done err
    vecs[0]  = '{0, -1, -1,  1,  2, -1};  // ALU
    vecs[1]  = '{1,  3,  3,  4,  5, -1};  // LOAD, mem_ready 3 cycles after start
    vecs[2]  = '{1, -1, -1, -1, -1,  5};  // LOAD timeout after 4 WAIT_MEM cycles
    vecs[3]  = '{1,  4,  4,  5,  6, -1};  // LOAD, mem_ready on the limit cycle
    vecs[4]  = '{1,  5,  6, -1, -1,  5};  // LOAD, mem_ready one cycle too late
    vecs[5]  = '{1,  0,  0, -1, -1,  5};  // mem_ready only in start cycle ignored
    vecs[6]  = '{1,  0,  1,  2,  3, -1};  // held into WAIT_MEM: sampled at once
    vecs[7]  = '{2,  5,  5,  6,  7, -1};  // SHIFT after 5 cycles
    vecs[8]  = '{2,  1,  1,  2,  3, -1};  // SHIFT minimum latency
    vecs[9]  = '{2,  0,  8,  2,  3, -1};  // shift_done held from start cycle
    vecs[10] = '{6,  0,  3,  1,  2, -1};  // EXC_CONST, handshakes ignored
    vecs[11] = '{7, -1, -1, -1, -1,  1};  // invalid class
    vecs[12] = '{3, -1, -1,  1,  2, -1};  // LINK
    vecs[13] = '{4,  1,  2,  1,  2, -1};  // LUI
    vecs[14] = '{5, -1, -1,  1,  2, -1};  // SIGNEXT

    // Reset state
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("reset_outputs", 0, outs_packed(), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_outputs", 0, outs_packed(), 0);

    // Table-driven transactions; a conflicting start (op 7) is issued in
    // cycle 1 of every transaction and must be ignored.
    for (int i = 0; i < NVEC; i++) begin
      rw_first = -1; rw_n = 0; done_first = -1; done_n = 0;
      err_first = -1; err_n = 0; busy_n = 0; sel_bad = 0; idle_bad = 0;
      for (int k = 0; k < WINDOW; k++) begin
        @(negedge clk);
        if (bus.RegWrite) begin
          rw_n++;
          if (rw_first < 0) rw_first = k;
        end
        if (bus.done) begin
          done_n++;
          if (done_first < 0) done_first = k;
        end
        if (bus.err) begin
          err_n++;
          if (err_first < 0) err_first = k;
        end
        if (bus.busy) begin
          busy_n++;
          if (int'(bus.w_MemToReg) != vecs[i].op) sel_bad++;
        end else if (bus.w_MemToReg != 3'd0) begin
          idle_bad++;
        end
        bus.start      = (k <= 1);
        bus.op_class   = (k == 0) ? 3'(vecs[i].op) : 3'd7;
        bus.mem_ready  = (k >= vecs[i].hs_lo) && (k <= vecs[i].hs_hi);
        bus.shift_done = (k >= vecs[i].hs_lo) && (k <= vecs[i].hs_hi);
      end
      drive_idle();
      end_cyc = (vecs[i].err_cyc >= 0) ? vecs[i].err_cyc : vecs[i].done_cyc;
      check("regwrite_cycle", i, rw_first, vecs[i].rw_cyc);
      check("regwrite_count", i, rw_n, (vecs[i].rw_cyc >= 0) ? 1 : 0);
      check("done_cycle", i, done_first, vecs[i].done_cyc);
      check("done_count", i, done_n, (vecs[i].done_cyc >= 0) ? 1 : 0);
      check("err_cycle", i, err_first, vecs[i].err_cyc);
      check("err_count", i, err_n, (vecs[i].err_cyc >= 0) ? 1 : 0);
      check("busy_cycles", i, busy_n, end_cyc);
      check("sel_while_busy_errors", i, sel_bad, 0);
      check("sel_in_idle_errors", i, idle_bad, 0);
      $display("vec %0d op=%0d rw@%0d done@%0d err@%0d busy=%0d", i, vecs[i].op,
               rw_first, done_first, err_first, busy_n);
    end

    // Reset during WAIT_MEM: outputs clear at once, later mem_ready ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op_class = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_wm_busy_before", 0, int'(bus.busy), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_wm_outputs_now", 0, outs_packed(), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    misc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      misc += outs_packed();
    end
    drive_idle();
    check("rst_wm_outputs_after", 0, misc, 0);
    $display("seq reset_in_wait_mem activity=%0d", misc);

    // Reset during WRITE: no RegWrite or done afterwards
    @(negedge clk);
    bus.start = 1'b1; bus.op_class = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_wr_regwrite_before", 0, int'(bus.RegWrite), 1);
    #2 reset = 1'b1;
    #1 check("rst_wr_outputs_now", 0, outs_packed(), 0);
    @(negedge clk);
    reset = 1'b0;
    misc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      misc += int'(bus.RegWrite) + int'(bus.done) + int'(bus.busy);
    end
    check("rst_wr_outputs_after", 0, misc, 0);
    $display("seq reset_in_write activity=%0d", misc);

    // Back-to-back after DONE: ALU, then LUI in the first IDLE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.op_class = 3'd0;      // cycle 0
    @(negedge clk); bus.start = 1'b0;           // cycle 1 WRITE
    @(negedge clk);                             // cycle 2 DONE
    check("b2b_done", 0, int'(bus.done), 1);
    @(negedge clk);                             // cycle 3 IDLE
    check("b2b_idle", 0, int'(bus.busy), 0);
    bus.start = 1'b1; bus.op_class = 3'd4;
    @(negedge clk); bus.start = 1'b0;           // cycle 4 WRITE
    check("b2b_regwrite", 0, int'(bus.RegWrite), 1);
    check("b2b_sel", 0, int'(bus.w_MemToReg), 4);
    @(negedge clk);                             // cycle 5 DONE
    check("b2b_done2", 0, int'(bus.done), 1);
    $display("seq back_to_back_after_done sel=4");

    // Back-to-back after ERR: invalid, then SHIFT in the first IDLE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.op_class = 3'd7;      // cycle 0
    @(negedge clk); bus.start = 1'b0;           // cycle 1 ERR
    check("b2b_err", 0, int'(bus.err), 1);
    check("b2b_err_sel", 0, int'(bus.w_MemToReg), 7);
    @(negedge clk);                             // cycle 2 IDLE
    bus.start = 1'b1; bus.op_class = 3'd2;
    @(negedge clk);                             // cycle 3 WAIT_SHIFT
    bus.start = 1'b0; bus.shift_done = 1'b1;
    check("b2b_wait_shift", 0, outs_packed(), {25'd0, 3'd2, 4'b0100});
    @(negedge clk);                             // cycle 4 WRITE
    bus.shift_done = 1'b0;
    check("b2b_shift_regwrite", 0, outs_packed(), {25'd0, 3'd2, 4'b1100});
    repeat (2) @(negedge clk);
    check("b2b_final_idle", 0, outs_packed(), 0);
    $display("seq back_to_back_after_err sel=2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
